// File: rtl/eth_wb_arb_pkg.sv
// Shared types and constants for the Ethernet MAC Wishbone master arbiter.
package eth_wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StBus,
    StDone
  } arb_state_e;

  typedef enum logic {
    OWN_TX = 1'b0,
    OWN_RX = 1'b1
  } owner_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_TX) ? OWN_RX : OWN_TX;
  endfunction

endpackage

// File: rtl/eth_wb_rr_arb.sv
// Two-way round-robin arbiter. ptr_q names the requester that wins a tie;
// after each granted burst it moves to the other requester.
module eth_wb_rr_arb
  import eth_wb_arb_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   req_tx_i,
  input  logic   req_rx_i,
  input  logic   update_i,
  output owner_e grant_o
);

  owner_e ptr_q, ptr_d;

  // Grant decode: tie goes to the pointer, otherwise the sole requester
  always_comb begin
    grant_o = OWN_TX;
    if (req_tx_i && req_rx_i) begin
      grant_o = ptr_q;
    end else if (req_rx_i) begin
      grant_o = OWN_RX;
    end
    ptr_d = update_i ? other_owner(grant_o) : ptr_q;
  end

  // Priority pointer register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= OWN_TX;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/eth_wb_master_arb.sv
// Shares the MAC Wishbone master port between the TX and RX DMA requesters.
// Round-robin grant per burst; single or linear incrementing bursts.
// Optional macro WB_ARB_TIMEOUT_EN adds a watchdog that aborts a stalled bus cycle.
module eth_wb_master_arb
  import eth_wb_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,

  input  logic             tx_req_i,
  input  logic [31:0]      tx_adr_i,
  input  logic             tx_we_i,
  input  logic [3:0]       tx_sel_i,
  input  logic [LEN_W-1:0] tx_len_i,
  input  logic [31:0]      tx_dat_i,
  output logic [31:0]      tx_dat_o,
  output logic             tx_ack_o,
  output logic             tx_err_o,
  output logic             tx_done_o,

  input  logic             rx_req_i,
  input  logic [31:0]      rx_adr_i,
  input  logic             rx_we_i,
  input  logic [3:0]       rx_sel_i,
  input  logic [LEN_W-1:0] rx_len_i,
  input  logic [31:0]      rx_dat_i,
  output logic [31:0]      rx_dat_o,
  output logic             rx_ack_o,
  output logic             rx_err_o,
  output logic             rx_done_o,

  output logic [31:0]      m_wb_adr_o,
  output logic [3:0]       m_wb_sel_o,
  output logic             m_wb_we_o,
  output logic [31:0]      m_wb_dat_o,
  input  logic [31:0]      m_wb_dat_i,
  output logic             m_wb_cyc_o,
  output logic             m_wb_stb_o,
  input  logic             m_wb_ack_i,
  input  logic             m_wb_err_i,
  output logic [2:0]       m_wb_cti_o,
  output logic [1:0]       m_wb_bte_o
);

  if (MAX_BURST < 1 || MAX_BURST > 16 || MAX_BURST > (1 << LEN_W) || TIMEOUT_CYC < 2)
  begin : g_bad_param
    $error("eth_wb_master_arb: illegal parameter value");
  end

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             tx_req_q, tx_req_d;
  logic             rx_req_q, rx_req_d;
  logic [31:0]      adr_q, adr_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  owner_e           grant;
  logic             arb_update;
  logic             bus_active;
  logic             bus_ack;
  logic             bus_err;
  logic             last_beat;
  logic             timeout_hit;
  logic [31:0]      req_adr;
  logic [LEN_W-1:0] req_len;

  assign bus_active = (state_q == StBus);
  assign last_beat  = (cnt_q == len_q);
  // Error (bus or watchdog) takes precedence over a coincident ack
  assign bus_err    = bus_active && (m_wb_err_i || timeout_hit);
  assign bus_ack    = bus_active && m_wb_ack_i && !bus_err;
  assign arb_update = (state_q == StArb);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC - 1);

  logic [TmoW-1:0] tmo_q;

  assign timeout_hit = bus_active && (tmo_q == TmoMax) && !m_wb_ack_i && !m_wb_err_i;

  // Watchdog: restarts on every bus response and whenever the bus is idle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_q <= '0;
    end else if (!bus_active || m_wb_ack_i || m_wb_err_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TmoW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  eth_wb_rr_arb u_rr_arb (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .req_tx_i (tx_req_q),
    .req_rx_i (rx_req_q),
    .update_i (arb_update),
    .grant_o  (grant)
  );

  // Granted requester's command fields, length clamped to the burst limit
  always_comb begin
    req_adr = (grant == OWN_RX) ? rx_adr_i : tx_adr_i;
    req_len = (grant == OWN_RX) ? rx_len_i : tx_len_i;
    if (req_len > MaxLen) begin
      req_len = MaxLen;
    end
  end

  // Next-state logic for the burst FSM and its datapath registers
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    tx_req_d = tx_req_q;
    rx_req_d = rx_req_q;
    adr_d    = adr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (tx_req_i || rx_req_i) begin
          tx_req_d = tx_req_i;
          rx_req_d = rx_req_i;
          state_d  = StArb;
        end
      end
      StArb: begin
        owner_d = grant;
        adr_d   = req_adr & 32'hFFFF_FFFC;
        we_d    = (grant == OWN_RX) ? rx_we_i : tx_we_i;
        sel_d   = (grant == OWN_RX) ? rx_sel_i : tx_sel_i;
        len_d   = req_len;
        cnt_d   = '0;
        state_d = StBus;
      end
      StBus: begin
        if (bus_err) begin
          state_d = StDone;
        end else if (bus_ack) begin
          adr_d = adr_q + 32'd4;
          cnt_d = cnt_q + LEN_W'(1);
          if (last_beat) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      owner_q  <= OWN_TX;
      tx_req_q <= 1'b0;
      rx_req_q <= 1'b0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      tx_req_q <= tx_req_d;
      rx_req_q <= rx_req_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  // Bus-side and requester-side outputs, steered by the current owner
  always_comb begin
    m_wb_cyc_o = bus_active;
    m_wb_stb_o = bus_active;
    m_wb_adr_o = adr_q;
    m_wb_sel_o = sel_q;
    m_wb_we_o  = we_q;
    m_wb_bte_o = BTE_LINEAR;
    m_wb_dat_o = '0;
    m_wb_cti_o = CTI_CLASSIC;
    if (bus_active) begin
      m_wb_dat_o = (owner_q == OWN_RX) ? rx_dat_i : tx_dat_i;
      if (len_q != '0) begin
        m_wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;
      end
    end

    tx_ack_o  = bus_ack && (owner_q == OWN_TX);
    rx_ack_o  = bus_ack && (owner_q == OWN_RX);
    tx_err_o  = bus_err && (owner_q == OWN_TX);
    rx_err_o  = bus_err && (owner_q == OWN_RX);
    tx_done_o = (state_q == StDone) && (owner_q == OWN_TX);
    rx_done_o = (state_q == StDone) && (owner_q == OWN_RX);
    tx_dat_o  = tx_ack_o ? m_wb_dat_i : '0;
    rx_dat_o  = rx_ack_o ? m_wb_dat_i : '0;
  end

endmodule
